simple_dma: RTL and testbench

Single-channel memory-to-memory copy engine that acts as a second bus host in the simple system. It exposes a small register file as a bus device, for programming by the core. It then copies a block of 32-bit words using the same req/gnt/rvalid host protocol that the core data port drives into the bus. On completion it raises a level interrupt towards the core.

---
 rtl/simple_dma_if.sv | 19 +
 rtl/simple_dma.sv | 186 ++++++++++++++++++
 tb/tb_simple_dma.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simple_dma_if.sv
// simple_dma_if: req/gnt/rvalid bus bundle. The DMA register port uses the
// slave modport, its copy engine drives the master modport.
interface simple_dma_if #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32
);
   logic                 req;
   logic                 gnt;
   logic                 we;
   logic [3:0]           be;
   logic [AddrWidth-1:0] addr;
   logic [DataWidth-1:0] wdata;
   logic                 rvalid;
   logic [DataWidth-1:0] rdata;
   logic                 err;

   modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
   modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/simple_dma.sv
// simple_dma: single-channel word copy engine with a bus-device register file.
// Define SIMPLE_DMA_IRQ_EN to implement the IE bit and the completion interrupt.
module simple_dma #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   simple_dma_if.slave  dev,
   simple_dma_if.master host,
   output logic         irq_o
);
   typedef enum logic [2:0] {
      S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_FIN
   } state_e;

   localparam logic [7:0] OFF_SRC    = 8'h00;
   localparam logic [7:0] OFF_DST    = 8'h01;
   localparam logic [7:0] OFF_LEN    = 8'h02;
   localparam logic [7:0] OFF_CTRL   = 8'h03;
   localparam logic [7:0] OFF_STATUS = 8'h04;

   state_e               state_q, state_d;
   logic [AddrWidth-1:0] src_r, dst_r, src_q, dst_q;
   logic [DataWidth-1:0] len_r, cnt_q, data_q;
   logic                 done_r, err_r, ie_r;
   logic                 busy, wr_en, start, rsp_err;
   logic [7:0]           offset;
   logic [DataWidth-1:0] rd_mux;
   logic                 rd_hit;
   logic                 dev_rvalid_q, dev_err_q;
   logic [DataWidth-1:0] dev_rdata_q;
   logic                 unused_bits;

   assign busy    = (state_q != S_IDLE);
   assign offset  = dev.addr[9:2];
   assign wr_en   = dev.req && dev.we;
   assign start   = wr_en && (offset == OFF_CTRL) && dev.wdata[0] && !busy;
   assign rsp_err = host.rvalid && host.err &&
                    (state_q == S_RD_WAIT || state_q == S_WR_WAIT);

   assign unused_bits = ^{dev.be, dev.addr[AddrWidth-1:10], dev.addr[1:0]};

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      host.req   = 1'b0;
      host.we    = 1'b0;
      host.addr  = '0;
      host.wdata = '0;
      case (state_q)
         S_IDLE:    if (start && len_r != '0) state_d = S_RD_REQ;
         S_RD_REQ: begin
            host.req  = 1'b1;
            host.addr = src_q;
            if (host.gnt) state_d = S_RD_WAIT;
         end
         S_RD_WAIT: if (host.rvalid) state_d = host.err ? S_FIN : S_WR_REQ;
         S_WR_REQ: begin
            host.req   = 1'b1;
            host.we    = 1'b1;
            host.addr  = dst_q;
            host.wdata = data_q;
            if (host.gnt) state_d = S_WR_WAIT;
         end
         S_WR_WAIT: begin
            if (host.rvalid) begin
               if (host.err || cnt_q == DataWidth'(1)) state_d = S_FIN;
               else                                    state_d = S_RD_REQ;
            end
         end
         S_FIN:     state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   assign host.be = 4'hF;

   // Working copies advance; the programmed SRC/DST/LEN stay untouched.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         src_q  <= '0;
         dst_q  <= '0;
         cnt_q  <= '0;
         data_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && len_r != '0) begin
                  src_q <= src_r;
                  dst_q <= dst_r;
                  cnt_q <= len_r;
               end
            end
            S_RD_WAIT: if (host.rvalid) data_q <= host.rdata;
            S_WR_WAIT: begin
               if (host.rvalid && !host.err) begin
                  src_q <= src_q + AddrWidth'(4);
                  dst_q <= dst_q + AddrWidth'(4);
                  cnt_q <= cnt_q - DataWidth'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Later assignments take priority: FIN's DONE set overrides a same-cycle W1C.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         src_r  <= '0;
         dst_r  <= '0;
         len_r  <= '0;
         done_r <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         if (wr_en && !busy) begin
            case (offset)
               OFF_SRC: src_r <= {dev.wdata[AddrWidth-1:2], 2'b00};
               OFF_DST: dst_r <= {dev.wdata[AddrWidth-1:2], 2'b00};
               OFF_LEN: len_r <= dev.wdata;
               default: ;
            endcase
         end
         if (wr_en && offset == OFF_STATUS) begin
            if (dev.wdata[1]) done_r <= 1'b0;
            if (dev.wdata[2]) err_r  <= 1'b0;
         end
         if (start) begin
            if (len_r == '0) begin
               done_r <= 1'b1;
            end else begin
               done_r <= 1'b0;
               err_r  <= 1'b0;
            end
         end
         if (rsp_err)          err_r  <= 1'b1;
         if (state_q == S_FIN) done_r <= 1'b1;
      end
   end

`ifdef SIMPLE_DMA_IRQ_EN
   always_ff @(posedge clk_i) begin
      if (!rst_ni)                           ie_r <= 1'b0;
      else if (wr_en && offset == OFF_CTRL)  ie_r <= dev.wdata[1];
   end
   assign irq_o = done_r & ie_r;
`else
   assign ie_r  = 1'b0;
   assign irq_o = 1'b0;
`endif

   always_comb begin
      rd_mux = '0;
      rd_hit = 1'b1;
      case (offset)
         OFF_SRC:    rd_mux = src_r;
         OFF_DST:    rd_mux = dst_r;
         OFF_LEN:    rd_mux = len_r;
         OFF_CTRL:   rd_mux = {{(DataWidth-2){1'b0}}, ie_r, 1'b0};
         OFF_STATUS: rd_mux = {{(DataWidth-3){1'b0}}, err_r, done_r, busy};
         default:    rd_hit = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         dev_rvalid_q <= 1'b0;
         dev_rdata_q  <= '0;
         dev_err_q    <= 1'b0;
      end else begin
         dev_rvalid_q <= dev.req;
         dev_rdata_q  <= (dev.req && !dev.we) ? rd_mux : '0;
         dev_err_q    <= dev.req && !rd_hit;
      end
   end

   assign dev.gnt    = dev.req;
   assign dev.rvalid = dev_rvalid_q;
   assign dev.rdata  = dev_rdata_q;
   assign dev.err    = dev_err_q;
endmodule

// File: tb/tb_simple_dma.sv
// tb_simple_dma: directed bench for simple_dma with a transaction-level copy model
// and a bus memory responder (same-cycle grant, next-cycle rvalid).
module tb_simple_dma;
`ifdef SIMPLE_DMA_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic irq;
   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   simple_dma_if #(.AddrWidth(32), .DataWidth(32)) dev_bus ();
   simple_dma_if #(.AddrWidth(32), .DataWidth(32)) host_bus ();

   simple_dma #(.AddrWidth(32), .DataWidth(32)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .dev   (dev_bus),
      .host  (host_bus),
      .irq_o (irq)
   );

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } xact_t;

   xact_t       exp_q[$];
   logic [31:0] rom  [0:8191];
   logic [31:0] wmem [0:8191];
   int unsigned rd_count = 0;
   int unsigned wr_count = 0;
   int unsigned inject_at = 0;

   function automatic int unsigned widx(input logic [31:0] a);
      return int'({a[22:20], a[11:2]});
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   assign host_bus.gnt = host_bus.req;

   // Memory responder: reads come from rom, writes land in wmem.
   always @(posedge clk) begin
      host_bus.rvalid <= 1'b0;
      host_bus.err    <= 1'b0;
      if (host_bus.req && host_bus.gnt) begin
         host_bus.rvalid <= 1'b1;
         if (host_bus.we) begin
            wmem[widx(host_bus.addr)] <= host_bus.wdata;
            wr_count                  <= wr_count + 1;
            host_bus.rdata            <= '0;
         end else begin
            rd_count       <= rd_count + 1;
            host_bus.rdata <= rom[widx(host_bus.addr)];
            host_bus.err   <= (inject_at != 0) && (rd_count + 1 == inject_at);
         end
      end
   end

   // Every cycle the DUT requests the bus, the request must match the model's next transaction.
   always @(negedge clk) begin
      xact_t e;
      if (rst_n && host_bus.req) begin
         if (exp_q.size() == 0) begin
            check("host_unexpected_req", {31'b0, host_bus.req}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("host_we", {31'b0, host_bus.we}, {31'b0, e.we});
            check("host_addr", host_bus.addr, e.addr);
            if (e.we) check("host_wdata", host_bus.wdata, e.wdata);
            check("host_be", {28'b0, host_bus.be}, 32'hF);
         end
      end
   end

   task automatic plan_copy(input logic [31:0] src, input logic [31:0] dst,
                            input int unsigned len, input int unsigned keep);
      for (int unsigned i = 0; i < len; i++) begin
         exp_q.push_back('{we: 1'b0, addr: src + 4 * i, wdata: 32'h0});
         exp_q.push_back('{we: 1'b1, addr: dst + 4 * i, wdata: rom[widx(src + 4 * i)]});
      end
      while (exp_q.size() > keep) void'(exp_q.pop_back());
   endtask

   task automatic preload(input logic [31:0] src, input int unsigned len, input logic [31:0] seed);
      for (int unsigned i = 0; i < len; i++) rom[widx(src + 4 * i)] = seed + 32'h0101_0101 * i;
   endtask

   task automatic check_copy(input string name, input logic [31:0] src,
                             input logic [31:0] dst, input int unsigned len);
      for (int unsigned i = 0; i < len; i++)
         check(name, wmem[widx(dst + 4 * i)], rom[widx(src + 4 * i)]);
   endtask

   task automatic dev_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err);
      dev_bus.req   = 1'b1;
      dev_bus.we    = we;
      dev_bus.addr  = addr;
      dev_bus.wdata = wdata;
      @(posedge clk);
      @(negedge clk);
      dev_bus.req = 1'b0;
      dev_bus.we  = 1'b0;
      check("dev_rvalid", {31'b0, dev_bus.rvalid}, 32'd1);
      rdata = dev_bus.rdata;
      err   = dev_bus.err;
   endtask

   task automatic dev_write(input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] r;
      logic        e;
      dev_op(1'b1, addr, wdata, r, e);
   endtask

   task automatic dev_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] r;
      logic        e;
      logic [7:0]  off;
      dev_op(1'b0, addr, 32'h0, r, e);
      off = addr[9:2];
      check(name, r, exp);
      check({name, "_err"}, {31'b0, e}, {31'b0, off > 8'd4});
   endtask

   task automatic wait_idle(output int unsigned busy_n, output logic [31:0] st);
      logic e;
      busy_n = 0;
      st     = '0;
      for (int unsigned i = 0; i < 400; i++) begin
         dev_op(1'b0, 32'h10, 32'h0, st, e);
         if (!st[0]) return;
         busy_n++;
      end
      n_vec++;
      n_bad++;
      $display("FAIL busy_timeout: still busy after %0d cycles, required idle", busy_n);
   endtask

   task automatic wait_host_write(input logic [31:0] addr);
      for (int unsigned i = 0; i < 200; i++) begin
         @(negedge clk);
         if (host_bus.req && host_bus.we && host_bus.addr == addr) return;
      end
      n_vec++;
      n_bad++;
      $display("FAIL host_write_timeout: no write to %h seen, required one", addr);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required $finish");
      $fatal(1);
   end

   initial begin
      int unsigned busy_n;
      int unsigned wr_base, rd_base;
      logic [31:0] st;

      dev_bus.req   = 1'b0;
      dev_bus.we    = 1'b0;
      dev_bus.be    = 4'hF;
      dev_bus.addr  = '0;
      dev_bus.wdata = '0;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_host_req",   {31'b0, host_bus.req}, 32'd0);
      check("rst_host_we",    {31'b0, host_bus.we}, 32'd0);
      check("rst_host_addr",  host_bus.addr, 32'd0);
      check("rst_host_wdata", host_bus.wdata, 32'd0);
      check("rst_host_be",    {28'b0, host_bus.be}, 32'hF);
      check("rst_dev_rvalid", {31'b0, dev_bus.rvalid}, 32'd0);
      check("rst_dev_rdata",  dev_bus.rdata, 32'd0);
      check("rst_dev_err",    {31'b0, dev_bus.err}, 32'd0);
      check("rst_irq",        {31'b0, irq}, 32'd0);
      rst_n = 1'b1;
      dev_read("rst_status", 32'h10, 32'h0);
      dev_read("rst_len",    32'h08, 32'h0);

      // Unmapped offset and address low-bit masking
      dev_read("bad_offset", 32'h14, 32'h0);
      dev_write(32'h20, 32'hFFFF_FFFF);
      dev_write(32'h00, 32'h0010_0003);
      dev_write(32'h04, 32'h0010_0402);
      dev_write(32'h08, 32'd4);
      dev_read("src_masked", 32'h00, 32'h0010_0000);
      dev_read("dst_masked", 32'h04, 32'h0010_0400);
      dev_read("len_rb",     32'h08, 32'd4);

      // Four-word copy
      rom[widx(32'h0010_0000)] = 32'h11;
      rom[widx(32'h0010_0004)] = 32'h22;
      rom[widx(32'h0010_0008)] = 32'h33;
      rom[widx(32'h0010_000C)] = 32'h44;
      plan_copy(32'h0010_0000, 32'h0010_0400, 4, 8);
      dev_write(32'h0C, 32'h1);
      wait_idle(busy_n, st);
      check("copy_busy_cycles", busy_n, 32'(4 * 4 + 1));
      check("copy_busy_17",     busy_n, 32'd17);
      check("copy_status",      st, 32'h2);
      check_copy("copy_data", 32'h0010_0000, 32'h0010_0400, 4);
      check("copy_dst0", wmem[widx(32'h0010_0400)], 32'h11);
      check("copy_dst3", wmem[widx(32'h0010_040C)], 32'h44);
      check("copy_drained", 32'(exp_q.size()), 32'd0);
      dev_read("copy_src_kept", 32'h00, 32'h0010_0000);
      dev_read("copy_len_kept", 32'h08, 32'd4);

      // LEN=0: DONE without bus traffic
      dev_write(32'h10, 32'h2);
      dev_read("len0_cleared", 32'h10, 32'h0);
      wr_base = wr_count;
      rd_base = rd_count;
      dev_write(32'h08, 32'd0);
      dev_write(32'h0C, 32'h1);
      dev_read("len0_status", 32'h10, 32'h2);
      repeat (3) @(negedge clk);
      check("len0_no_traffic", 32'((wr_count - wr_base) + (rd_count - rd_base)), 32'd0);

      // Bus error on the second read of a three-word copy
      preload(32'h0020_0000, 3, 32'hA000_0000);
      dev_write(32'h00, 32'h0020_0000);
      dev_write(32'h04, 32'h0020_0400);
      dev_write(32'h08, 32'd3);
      plan_copy(32'h0020_0000, 32'h0020_0400, 3, 3);
      wr_base   = wr_count;
      inject_at = rd_count + 2;
      dev_write(32'h0C, 32'h1);
      wait_idle(busy_n, st);
      inject_at = 0;
      check("err_status", st, 32'h6);
      check("err_one_write", 32'(wr_count - wr_base), 32'd1);
      check("err_first_word", wmem[widx(32'h0020_0400)], rom[widx(32'h0020_0000)]);
      check("err_drained", 32'(exp_q.size()), 32'd0);

      // Busy protection, then W1C DONE in the FIN cycle
      preload(32'h0030_0000, 4, 32'h5000_0001);
      dev_write(32'h00, 32'h0030_0000);
      dev_write(32'h04, 32'h0030_0400);
      dev_write(32'h08, 32'd4);
      plan_copy(32'h0030_0000, 32'h0030_0400, 4, 8);
      dev_write(32'h0C, 32'h1);
      dev_read("busy_status_err_clr", 32'h10, 32'h1);
      wait_host_write(32'h0030_0400);
      dev_write(32'h00, 32'hDEAD_0000);
      dev_write(32'h0C, 32'h1);
      wait_host_write(32'h0030_040C);
      repeat (2) @(negedge clk);
      dev_write(32'h10, 32'h2);
      dev_read("fin_w1c_done_kept", 32'h10, 32'h2);
      dev_read("busy_src_kept", 32'h00, 32'h0030_0000);
      check_copy("busy_data", 32'h0030_0000, 32'h0030_0400, 4);
      check("busy_drained", 32'(exp_q.size()), 32'd0);

      // Interrupt
      preload(32'h0050_0000, 1, 32'h7777_0000);
      dev_write(32'h0C, 32'h2);
      dev_read("ctrl_ie", 32'h0C, IRQ_EN ? 32'h2 : 32'h0);
      dev_write(32'h00, 32'h0050_0000);
      dev_write(32'h04, 32'h0050_0400);
      dev_write(32'h08, 32'd1);
      plan_copy(32'h0050_0000, 32'h0050_0400, 1, 2);
      dev_write(32'h0C, 32'h3);
      check("irq_low_busy", {31'b0, irq}, 32'd0);
      wait_idle(busy_n, st);
      check("irq_busy_cycles", busy_n, 32'd5);
      check("irq_done", {31'b0, irq}, {31'b0, IRQ_EN});
      dev_write(32'h10, 32'h2);
      check("irq_cleared", {31'b0, irq}, 32'd0);

      // Reset while WR_WAIT
      preload(32'h0040_0000, 2, 32'h3000_0000);
      dev_write(32'h00, 32'h0040_0000);
      dev_write(32'h04, 32'h0040_0400);
      dev_write(32'h08, 32'd2);
      plan_copy(32'h0040_0000, 32'h0040_0400, 2, 4);
      dev_write(32'h0C, 32'h1);
      wait_host_write(32'h0040_0400);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      exp_q.delete();
      check("mrst_host_req",  {31'b0, host_bus.req}, 32'd0);
      check("mrst_host_addr", host_bus.addr, 32'd0);
      check("mrst_irq",       {31'b0, irq}, 32'd0);
      rst_n = 1'b1;
      dev_read("mrst_status", 32'h10, 32'h0);
      dev_read("mrst_src",    32'h00, 32'h0);
      dev_write(32'h00, 32'h0040_0000);
      dev_write(32'h04, 32'h0040_0800);
      dev_write(32'h08, 32'd1);
      plan_copy(32'h0040_0000, 32'h0040_0800, 1, 2);
      dev_write(32'h0C, 32'h1);
      wait_idle(busy_n, st);
      check("mrst_busy_cycles", busy_n, 32'd5);
      check("mrst_status_done", st, 32'h2);
      check("mrst_copy", wmem[widx(32'h0040_0800)], 32'h3000_0000);
      check("mrst_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
